fp_mul_seq: RTL
===============

Name: fp_mul_seq

Overview:
- Parametrised, multi-cycle IEEE-754 binary floating-point multiplier with valid/ready handshakes on input and output.
- Classifies operands, multiplies significands by iterative shift-add, normalises, and rounds in one of five RISC-V rounding modes; produces RISC-V fflags.
- Successor to the combinational single-precision multiply/round path. Sits in the FPU execute stage behind the operand-issue logic.

Parameters:
- EXP_W, 8, exponent width (>=4)
- MAN_W, 23, stored fraction width (>=4); FLEN = 1+EXP_W+MAN_W (localparam)

Ports:
- clk, in, 1, clock
- rst_n, in, 1, synchronous active-low reset
- in_valid, in, 1, operand/rm valid
- in_ready, out, 1, block idle; accepts when in_valid && in_ready
- in_a, in, FLEN, operand A
- in_b, in, FLEN, operand B
- in_rm, in, 3, rounding mode (000 RNE, 001 RTZ, 010 RDN, 011 RUP, 100 RMM)
- out_valid, out, 1, result valid
- out_ready, in, 1, consumer accepts result
- out_res, out, FLEN, rounded product
- out_flags, out, 5, {NV,DZ,OF,UF,NX}; DZ always 0
- busy, out, 1, operation in flight (state != IDLE)

Behaviour:
- Single clock domain, one clock; reset is synchronous and active-low (rst_n sampled on rising clk).
- Reset values: in_ready=1, out_valid=0, busy=0, out_res=0, out_flags=0, state=IDLE.
- Reset mid-operation aborts the operation. Next cycle: IDLE, out_valid=0, in_ready=1. No result is emitted.
- FSM: IDLE -> CLASS -> MUL -> NORM -> RND -> DONE -> IDLE.
  - IDLE: in_ready=1. On accept, latch in_a, in_b, in_rm.
  - CLASS, 1 cycle: classify via fp_classify. Subnormal significand gets implicit bit 0 and exponent 1-bias. Special cases set a bypass result but still traverse all states.
  - MUL, MAN_W+1 cycles: radix-2 shift-add over the (MAN_W+1)-bit significands into a 2*(MAN_W+1)-bit product register. Counter runs 0..MAN_W.
  - NORM, 1 cycle: leading-zero count, left shift, and exponent adjust. If the unbiased exponent is below emin, right-shift into the subnormal range, OR-ing shifted-out bits into sticky. Keeps MAN_W+1 bits plus G, R, S.
  - RND, 1 cycle: apply rounding, then renormalise on mantissa carry-out (exponent+1).
  - DONE: out_valid=1. out_res and out_flags are held stable until out_ready. Transition to IDLE on out_ready.
- Latency: out_valid rises exactly MAN_W+4 cycles after the accept edge (27 for defaults), for all inputs including specials.
- Throughput: one operation in flight. in_ready=0 from the cycle after accept until the cycle after the output handshake. in_valid while busy is ignored. No combinational path from out_ready to in_ready.
- Sign: sign(a) XOR sign(b) for all non-NaN results, including zero and inf.
- Specials:
  - any sNaN -> canonical NaN (sign 0, exp all-ones, fraction MSB only), NV=1
  - qNaN -> canonical NaN, no flags
  - inf * 0 -> canonical NaN, NV
  - inf * finite-nonzero -> signed inf, no flags
  - zero * finite -> signed zero, no flags
- Overflow (rounded exponent >= all-ones), with OF=NX=1:
  - RNE, RMM -> signed inf
  - RTZ -> signed max-finite
  - RDN -> +max-finite / -inf
  - RUP -> +inf / -max-finite
- Underflow: tininess detected after rounding. UF=1 only if tiny and inexact.
- NX: set whenever G|R|S != 0 or overflow occurs.
- Reserved in_rm values 101..111 are treated as RNE with no extra flag.

Decomposition:
- Package fp_pkg holds:
  - rounding-mode encoding constants
  - flag bit indices
  - FSM state enum
  - canonical-NaN and max-finite constant functions of (EXP_W, MAN_W)
- One sub-module, fp_classify: parametrised, combinational, single operand. Outputs is_norm, is_subnorm, is_zero, is_inf, is_snan, is_qnan.

Test Plan:
- 3F800000 * 40000000, rm=RNE -> 40000000, flags 00000, out_valid exactly 27 cycles after accept.
- 7F7FFFFF * 40000000: rm=RTZ -> 7F7FFFFF, flags 00101; rm=RNE -> 7F800000, flags 00101; with a=FF7FFFFF and rm=RUP -> FF7FFFFF.
- 7F800000 * 00000000 -> 7FC00000, flags 10000; 7F800001 * 3F800000 -> 7FC00000, flags 10000; 7FC00001 * 3F800000 -> 7FC00000, flags 00000.
- 00000001 * 3F000000 (tie at 2^-150): rm=RNE -> 00000000, flags 00011; rm=RUP -> 00000001, flags 00011; 80000001 * 3F000000 with rm=RDN -> 80000001.
- Hold out_ready=0 for 5 cycles after out_valid -> out_res/out_flags stable, in_ready=0, in_valid pulses ignored. Then start a new op, assert rst_n=0 during MUL -> next cycle out_valid=0, in_ready=1, and no result is ever emitted.
- EXP_W=5, MAN_W=10: 3C00 * C000 -> C000 at 14 cycles. 7BFF * 4000 with rm=RNE -> 7C00, flags 00101.

Source files
------------

// File: rtl/fp_pkg.sv
// Shared definitions for the sequential floating-point multiplier.
// Rounding modes, flag positions, FSM states and special-value constants.
package fp_pkg;

  localparam logic [2:0] RM_RNE = 3'b000;
  localparam logic [2:0] RM_RTZ = 3'b001;
  localparam logic [2:0] RM_RDN = 3'b010;
  localparam logic [2:0] RM_RUP = 3'b011;
  localparam logic [2:0] RM_RMM = 3'b100;

  localparam int FL_NV = 4;
  localparam int FL_DZ = 3;
  localparam int FL_OF = 2;
  localparam int FL_UF = 1;
  localparam int FL_NX = 0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLASS,
    S_MUL,
    S_NORM,
    S_RND,
    S_DONE
  } state_t;

  // Encodings are built in a 64-bit container and sliced by the user.
  function automatic logic [63:0] canon_nan(int ew, int mw);
    logic [63:0] v;
    v = '0;
    for (int i = 0; i < ew; i++) v[mw+i] = 1'b1;
    v[mw-1] = 1'b1;
    return v;
  endfunction

  function automatic logic [63:0] max_finite(int ew, int mw);
    logic [63:0] v;
    v = '0;
    for (int i = 1; i < ew; i++) v[mw+i] = 1'b1;
    for (int i = 0; i < mw; i++) v[i] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/fp_classify.sv
// Combinational IEEE-754 operand classifier.
// Exactly one output is high for any encoding.
module fp_classify #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic [EXP_W+MAN_W:0] op,
  output logic                 is_norm,
  output logic                 is_subnorm,
  output logic                 is_zero,
  output logic                 is_inf,
  output logic                 is_snan,
  output logic                 is_qnan
);

  logic [EXP_W-1:0] ex;
  logic [MAN_W-1:0] fr;
  logic             e_one;
  logic             e_nul;
  logic             f_nul;

  assign ex    = op[MAN_W +: EXP_W];
  assign fr    = op[MAN_W-1:0];
  assign e_one = &ex;
  assign e_nul = ~|ex;
  assign f_nul = ~|fr;

  assign is_norm    = ~e_one & ~e_nul;
  assign is_subnorm = e_nul & ~f_nul;
  assign is_zero    = e_nul & f_nul;
  assign is_inf     = e_one & f_nul;
  assign is_snan    = e_one & ~f_nul & ~fr[MAN_W-1];
  assign is_qnan    = e_one & fr[MAN_W-1];

endmodule

// File: rtl/fp_mul_seq.sv
// Multi-cycle IEEE-754 multiplier: classify, shift-add, normalise, round.
// One operation in flight; fixed latency regardless of operand class.
module fp_mul_seq
  import fp_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [EXP_W+MAN_W:0] in_a,
  input  logic [EXP_W+MAN_W:0] in_b,
  input  logic [2:0]           in_rm,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [EXP_W+MAN_W:0] out_res,
  output logic [4:0]           out_flags,
  output logic                 busy
);

  localparam int FLEN = 1 + EXP_W + MAN_W;
  localparam int SW   = MAN_W + 1;
  localparam int PW   = 2 * SW;
  localparam int XW   = EXP_W + $clog2(PW) + 3;
  localparam int LW   = $clog2(PW + 1);
  localparam int CW   = $clog2(SW);

  localparam logic signed [XW-1:0] BIAS  = XW'((1 << (EXP_W - 1)) - 1);
  localparam logic signed [XW-1:0] EMIN  = XW'(2 - (1 << (EXP_W - 1)));
  localparam logic signed [XW-1:0] EMAXB = XW'((1 << EXP_W) - 1);

  localparam logic [63:0]     CNAN64 = canon_nan(EXP_W, MAN_W);
  localparam logic [63:0]     MAXF64 = max_finite(EXP_W, MAN_W);
  localparam logic [FLEN-1:0] CNAN   = CNAN64[FLEN-1:0];
  localparam logic [FLEN-2:0] MAXF   = MAXF64[FLEN-2:0];

  function automatic logic rnd_up(
    input logic [2:0] rm,
    input logic       s,
    input logic       lsb,
    input logic       g,
    input logic       rs
  );
    case (rm)
      RM_RTZ:  return 1'b0;
      RM_RDN:  return s & (g | rs);
      RM_RUP:  return ~s & (g | rs);
      RM_RMM:  return g;
      default: return g & (rs | lsb);
    endcase
  endfunction

  state_t state_q, state_d;

  logic [FLEN-1:0]        a_q, b_q, byp_res_q;
  logic [2:0]             rm_q;
  logic                   sign_q, byp_q, byp_nv_q;
  logic signed [XW-1:0]   exp_q, eb_q;
  logic [PW-1:0]          mcand_q, prod_q;
  logic [SW-1:0]          mlier_q, mant_q;
  logic [CW-1:0]          cnt_q;
  logic                   g_q, r_q, s_q;
  logic                   tiny_q, near_q, g2_q, rs2_q;

  logic a_norm, a_sub, a_zero, a_inf, a_snan, a_qnan;
  logic b_norm, b_sub, b_zero, b_inf, b_snan, b_qnan;

  fp_classify #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_cls_a (
    .op(a_q), .is_norm(a_norm), .is_subnorm(a_sub), .is_zero(a_zero),
    .is_inf(a_inf), .is_snan(a_snan), .is_qnan(a_qnan)
  );

  fp_classify #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_cls_b (
    .op(b_q), .is_norm(b_norm), .is_subnorm(b_sub), .is_zero(b_zero),
    .is_inf(b_inf), .is_snan(b_snan), .is_qnan(b_qnan)
  );

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign busy      = (state_q != S_IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (in_valid) state_d = S_CLASS;
      S_CLASS: state_d = S_MUL;
      S_MUL:   if (cnt_q == CW'(MAN_W)) state_d = S_NORM;
      S_NORM:  state_d = S_RND;
      S_RND:   state_d = S_DONE;
      S_DONE:  if (out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  logic                 c_sign, c_nv, c_byp;
  logic [FLEN-1:0]      c_res;
  logic signed [XW-1:0] ea, eb;
  logic [SW-1:0]        a_sig, b_sig;

  always_comb begin
    c_sign = a_q[FLEN-1] ^ b_q[FLEN-1];
    c_nv   = a_snan | b_snan | (a_inf & b_zero) | (a_zero & b_inf);
    c_byp  = 1'b1;
    c_res  = CNAN;
    if (c_nv | a_qnan | b_qnan) c_res = CNAN;
    else if (a_inf | b_inf)
      c_res = {c_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    else if (a_zero | b_zero)
      c_res = {c_sign, {(FLEN-1){1'b0}}};
    else c_byp = 1'b0;
    ea = a_sub ? EMIN : $signed(XW'(a_q[MAN_W +: EXP_W])) - BIAS;
    eb = b_sub ? EMIN : $signed(XW'(b_q[MAN_W +: EXP_W])) - BIAS;
    a_sig = {a_norm, a_q[MAN_W-1:0]};
    b_sig = {b_norm, b_q[MAN_W-1:0]};
  end

  logic [LW-1:0]        lz;
  logic signed [XW-1:0] lz_s, e_n, e_fin;
  logic [XW-1:0]        sh;
  logic [PW-1:0]        pn, shd;
  logic                 lost, n_tiny;

  // Normalise so the product MSB lands on bit PW-1, then denormalise if tiny.
  always_comb begin
    lz = LW'(PW);
    for (int i = 0; i < PW; i++) if (prod_q[i]) lz = LW'(PW - 1 - i);
    lz_s   = XW'(lz);
    pn     = prod_q << lz;
    e_n    = exp_q + XW'(1) - lz_s;
    n_tiny = (e_n < EMIN);
    sh     = n_tiny ? XW'(EMIN - e_n) : '0;
    e_fin  = n_tiny ? EMIN : e_n;
    shd    = pn >> sh;
    lost   = |(pn & ~({PW{1'b1}} << sh));
  end

  logic [SW:0]          sum;
  logic [SW-1:0]        mant_f;
  logic signed [XW-1:0] eb_f;
  logic                 up, nx, ovf, tiny;
  logic [FLEN-1:0]      r_res, ovf_res;
  logic [EXP_W-1:0]     ef;

  always_comb begin
    up   = rnd_up(rm_q, sign_q, mant_q[0], g_q, r_q | s_q);
    nx   = g_q | r_q | s_q;
    sum  = {1'b0, mant_q} + (SW+1)'(up);
    mant_f = sum[SW] ? sum[SW:1] : sum[SW-1:0];
    eb_f   = sum[SW] ? eb_q + XW'(1) : eb_q;
    ovf  = (eb_f >= EMAXB);
    // Unbounded-exponent rounding reaching 2^emin means the value is not tiny.
    tiny = tiny_q & ~(near_q & rnd_up(rm_q, sign_q, 1'b1, g2_q, rs2_q));
    ef   = mant_f[MAN_W] ? eb_f[EXP_W-1:0] : '0;
    r_res = {sign_q, ef, mant_f[MAN_W-1:0]};
    case (rm_q)
      RM_RTZ:  ovf_res = {sign_q, MAXF};
      RM_RDN:  ovf_res = sign_q ? {1'b1, {EXP_W{1'b1}}, {MAN_W{1'b0}}}
                                : {1'b0, MAXF};
      RM_RUP:  ovf_res = sign_q ? {1'b1, MAXF}
                                : {1'b0, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      default: ovf_res = {sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_res   <= '0;
      out_flags <= '0;
      cnt_q     <= '0;
    end else begin
      case (state_q)
        S_IDLE: if (in_valid) begin
          a_q  <= in_a;
          b_q  <= in_b;
          rm_q <= in_rm;
        end
        S_CLASS: begin
          sign_q    <= c_sign;
          exp_q     <= ea + eb;
          mcand_q   <= {{(PW-SW){1'b0}}, a_sig};
          mlier_q   <= b_sig;
          prod_q    <= '0;
          cnt_q     <= '0;
          byp_q     <= c_byp;
          byp_res_q <= c_res;
          byp_nv_q  <= c_nv;
        end
        S_MUL: begin
          prod_q  <= prod_q + (mlier_q[0] ? mcand_q : '0);
          mcand_q <= mcand_q << 1;
          mlier_q <= mlier_q >> 1;
          cnt_q   <= cnt_q + CW'(1);
        end
        S_NORM: begin
          mant_q <= shd[PW-1 -: SW];
          g_q    <= shd[MAN_W];
          r_q    <= shd[MAN_W-1];
          s_q    <= (|shd[MAN_W-2:0]) | lost;
          eb_q   <= e_fin + BIAS;
          tiny_q <= n_tiny;
          near_q <= (e_n == EMIN - XW'(1)) && (&pn[PW-1 -: SW]);
          g2_q   <= pn[MAN_W];
          rs2_q  <= |pn[MAN_W-1:0];
        end
        S_RND: begin
          if (byp_q) begin
            out_res   <= byp_res_q;
            out_flags <= {byp_nv_q, 4'b0000};
          end else begin
            out_res   <= ovf ? ovf_res : r_res;
            out_flags <= {1'b0, 1'b0, ovf, tiny & nx, nx | ovf};
          end
        end
        default: ;
      endcase
    end
  end

endmodule
